// File: rtl/instr_loader_pkg.sv
// Shared sizing constants and FSM state encoding for the instruction loader.
package instr_loader_pkg;

    localparam int unsigned DEPTH          = 32;
    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Collects LSB-first bytes into a 32-bit word; word_c already includes the byte
// being accepted this cycle so the word can be captured on the 4th handshake.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_byte_c,
    output logic [WORD_W-1:0] word_c
);

    logic [LANE_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] lanes_q, lanes_d;

    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        if (clear_i) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (accept_i) begin
            for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                if (idx_q == LANE_W'(i)) begin
                    lanes_d[i*BYTE_W +: BYTE_W] = byte_i;
                end
            end
            idx_d = idx_q + LANE_W'(1);
        end
    end

    assign word_c      = lanes_d;
    assign last_byte_c = accept_i && !clear_i && (idx_q == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader: streams bytes into 32-bit words, writes them to
// instruction memory from address 0 and holds the core in reset until done.
module instr_loader #(
    parameter int unsigned DEPTH  = instr_loader_pkg::DEPTH,
    parameter int unsigned ADDR_W = instr_loader_pkg::ADDR_W
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [ADDR_W:0]                     word_count,
    input  logic                                in_valid,
    input  logic [instr_loader_pkg::BYTE_W-1:0] in_data,
    output logic                                in_ready,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [instr_loader_pkg::WORD_W-1:0] mem_wdata,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                core_rst
);

    import instr_loader_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                core_rst_q, core_rst_d;

    logic                pk_clear_c;
    logic                pk_accept_c;
    logic                pk_last_c;
    logic [WORD_W-1:0]   pk_word_c;
    logic                count_ok_c;
    logic                last_word_c;

    assign count_ok_c  = (word_count != '0) && (word_count <= (ADDR_W+1)'(DEPTH));
    assign last_word_c = ({1'b0, word_idx_q} == (count_q - (ADDR_W+1)'(1)));
    // in_ready_q is only ever high in RECV, so it doubles as the state qualifier
    assign pk_accept_c = in_valid && in_ready_q;

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (pk_clear_c),
        .accept_i    (pk_accept_c),
        .byte_i      (in_data),
        .last_byte_c (pk_last_c),
        .word_c      (pk_word_c)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        pk_clear_c  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (count_ok_c) begin
                        state_d    = ST_RECV;
                        count_d    = word_count;
                        word_idx_d = '0;
                        err_d      = 1'b0;
                        pk_clear_c = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (pk_last_c) begin
                    state_d     = ST_WRITE;
                    mem_addr_d  = word_idx_q;
                    mem_wdata_d = pk_word_c;
                end
            end
            ST_WRITE: begin
                if (last_word_c) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_RECV;
                    word_idx_d = word_idx_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RECV);
        mem_we_d   = (state_d == ST_WRITE);
        busy_d     = (state_d == ST_RECV) || (state_d == ST_WRITE);
        done_d     = (state_d == ST_DONE);
        core_rst_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            word_idx_q  <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_rst_q  <= core_rst_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign core_rst  = core_rst_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random byte streams compared against a
// word-level model of the expected memory writes.
module tb_instr_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              core_rst;

    int tests_run    = 0;
    int tests_failed = 0;

    int unsigned wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] exp_words[$];
    int          ready_viol = 0;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst   (core_rst)
    );

    always #5 clk = ~clk;

    // Write observer: logs every strobe and notes any overlap with in_ready
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_log.push_back(int'(mem_addr));
            wr_data_log.push_back(mem_wdata);
            if (in_ready !== 1'b0) ready_viol++;
        end
    end

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        ready_viol = 0;
    endtask

    task automatic do_start(input int cnt);
        @(negedge clk);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(cnt);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit acc;
        acc = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 40; c++) begin
            if (in_ready === 1'b1) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte: in_ready never rose, got %b required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input int max_gap);
        logic [7:0]  b [4];
        logic [31:0] w;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(255, 0));
        w = 32'(b[0]) + (32'(b[1]) * 32'd256) + (32'(b[2]) * 32'd65536) + (32'(b[3]) * 32'd16777216);
        exp_words.push_back(w);
        for (int i = 0; i < 4; i++) send_byte(b[i], max_gap);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_done: done stayed %b, required 1", done);
        end
    endtask

    task automatic load(input int n, input int max_gap);
        exp_words.delete();
        for (int w = 0; w < n; w++) send_word(max_gap);
        wait_done();
    endtask

    task automatic check_writes(input string tag, input int n);
        tests_run++;
        if (wr_addr_log.size() !== n) begin
            tests_failed++;
            $display("FAIL %s write_count: got %0d required %0d", tag, wr_addr_log.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests_run++;
                if (wr_addr_log[i] !== i || wr_data_log[i] !== exp_words[i]) begin
                    tests_failed++;
                    $display("FAIL %s write[%0d]: got addr %0d data %h required addr %0d data %h",
                             tag, i, wr_addr_log[i], wr_data_log[i], i, exp_words[i]);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if ({in_ready, mem_we, busy, done, err, core_rst} !== 6'b000001 ||
            mem_addr !== '0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s: got rdy/we/busy/done/err/crst=%b addr=%0d data=%h required 000001 0 00000000",
                     tag, {in_ready, mem_we, busy, done, err, core_rst}, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_release_idle");
    endtask

    task automatic test_single_word();
        logic [7:0] bytes [4];
        bytes[0] = 8'h93; bytes[1] = 8'h80; bytes[2] = 8'h80; bytes[3] = 8'h02;
        clear_logs();
        do_start(1);
        tests_run++;
        if ({busy, in_ready, core_rst} !== 3'b111) begin
            tests_failed++;
            $display("FAIL single_recv_entry: busy/rdy/crst got %b required 111", {busy, in_ready, core_rst});
        end
        for (int i = 0; i < 4; i++) send_byte(bytes[i], 0);
        @(negedge clk);
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== 32'h02808093 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h rdy=%b required 1 0 02808093 0",
                     mem_we, mem_addr, mem_wdata, in_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({done, core_rst, mem_we, busy} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL single_done: done/crst/we/busy got %b required 1000", {done, core_rst, mem_we, busy});
        end
        tests_run++;
        if (wr_addr_log.size() !== 1) begin
            tests_failed++;
            $display("FAIL single_pulses: got %0d required 1", wr_addr_log.size());
        end
    endtask

    task automatic test_multi_gaps();
        clear_logs();
        do_start(3);
        load(3, 3);
        check_writes("multi", 3);
        tests_run++;
        if (ready_viol !== 0) begin
            tests_failed++;
            $display("FAIL multi_ready_in_write: got %0d required 0", ready_viol);
        end
    endtask

    task automatic test_full();
        clear_logs();
        do_start(32);
        load(32, 1);
        check_writes("full", 32);
        tests_run++;
        if (done !== 1'b1 || mem_addr !== 5'd31) begin
            tests_failed++;
            $display("FAIL full_end: got done=%b addr=%0d required 1 31", done, mem_addr);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL full_extra_ready[%0d]: got %b required 0", i, in_ready);
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (wr_addr_log.size() !== 32 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_extra_byte: got writes=%0d done=%b required 32 1", wr_addr_log.size(), done);
        end
    endtask

    task automatic test_bad_count();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        do_start(0);
        @(negedge clk);
        tests_run++;
        if ({err, busy, core_rst} !== 3'b101) begin
            tests_failed++;
            $display("FAIL bad_count_zero: err/busy/crst got %b required 101", {err, busy, core_rst});
        end
        do_start(33);
        @(negedge clk);
        tests_run++;
        if ({err, busy, core_rst, in_ready} !== 4'b1010 || wr_addr_log.size() !== 0) begin
            tests_failed++;
            $display("FAIL bad_count_33: err/busy/crst/rdy got %b writes=%0d required 1010 0",
                     {err, busy, core_rst, in_ready}, wr_addr_log.size());
        end
        do_start(1);
        tests_run++;
        if ({err, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bad_count_recover: err/busy got %b required 01", {err, busy});
        end
        load(1, 0);
        check_writes("bad_count_load", 1);
    endtask

    task automatic test_reset_mid_load();
        do_start(2);
        clear_logs();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_load_async_reset");
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (wr_addr_log.size() !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_load_no_write: got writes=%0d busy=%b required 0 0", wr_addr_log.size(), busy);
        end
        do_start(1);
        load(1, 2);
        check_writes("mid_load_restart", 1);
    endtask

    task automatic test_reload_from_done();
        tests_run++;
        if ({done, core_rst} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reload_pre: done/crst got %b required 10", {done, core_rst});
        end
        clear_logs();
        exp_words.delete();
        do_start(2);
        tests_run++;
        if ({core_rst, done, busy} !== 3'b101) begin
            tests_failed++;
            $display("FAIL reload_entry: crst/done/busy got %b required 101", {core_rst, done, busy});
        end
        send_word(1);
        do_start(1);
        do_start(3);
        tests_run++;
        if ({busy, err, core_rst, done} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL reload_start_ignored: busy/err/crst/done got %b required 1010", {busy, err, core_rst, done});
        end
        send_word(1);
        wait_done();
        check_writes("reload", 2);
        tests_run++;
        if ({done, core_rst} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reload_done: done/crst got %b required 10", {done, core_rst});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_gaps();
        test_full();
        test_bad_count();
        test_reset_mid_load();
        test_reload_from_done();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
